// File: rtl/spi_flash_master.sv
// Mode-0 SPI master: one DATA_W-bit transfer per request, MSB first, with
// active-low chip selects that can be held across transfers and switched.
module spi_flash_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NUM_CS  = 2,
    parameter int unsigned DATA_W  = 8,
    localparam int unsigned SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              hold_cs,
    input  logic              cs_release,   // "release" is a reserved word
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic [NUM_CS-1:0] spi_cs_n,
    input  logic              spi_miso
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    generate
        if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_flash_master: CLK_DIV must be in 3..255");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                hold_q, hold_d;
    logic                held_q, held_d;
    logic                sw_q, sw_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_act_q, cs_act_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                miso_meta_q, miso_s;
    logic                div_last;

    assign div_last = (div_q == DIV_LAST);

    // Two-flop synchronizer for the asynchronous MISO pad
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_q <= 1'b0;
            miso_s      <= 1'b0;
        end else begin
            miso_meta_q <= spi_miso;
            miso_s      <= miso_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_sr_q    <= '0;
            sel_q      <= '0;
            hold_q     <= 1'b0;
            held_q     <= 1'b0;
            sw_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_act_q   <= 1'b0;
            cs_n_q     <= '1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_sr_q    <= rx_sr_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
            sw_q       <= sw_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_act_q   <= cs_act_d;
            cs_n_q     <= cs_n_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next state plus next value of every pad/handshake register
    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_sr_d    = rx_sr_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        held_d     = held_q;
        sw_d       = sw_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_act_d   = cs_act_q;

        if (state_q != S_IDLE) begin
            div_d = div_last ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                if (start) begin
                    tx_d   = tx_data;
                    sel_d  = cs_sel;
                    hold_d = hold_cs;
                    bit_d  = '0;
                    if (held_q && (cs_sel != sel_q)) begin
                        // switch target: deselect for one GAP first
                        state_d  = S_GAP;
                        sw_d     = 1'b1;
                        held_d   = 1'b0;
                        cs_act_d = 1'b0;
                        mosi_d   = 1'b0;
                    end else begin
                        state_d  = S_LEAD;
                        cs_act_d = 1'b1;
                        mosi_d   = tx_data[DATA_W-1];
                    end
                end else if (cs_release && held_q) begin
                    state_d  = S_GAP;
                    held_d   = 1'b0;
                    cs_act_d = 1'b0;
                    mosi_d   = 1'b0;
                end
            end
            S_LEAD: begin
                if (div_last) begin
                    state_d = S_HIGH;
                    sclk_d  = 1'b1;
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    state_d = S_LOW;
                    sclk_d  = 1'b0;
                    rx_sr_d = DATA_W'({rx_sr_q, miso_s});
                    if (bit_q != BIT_LAST) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_d[DATA_W-1];
                    end
                end
            end
            S_LOW: begin
                if (div_last) begin
                    if (bit_q != BIT_LAST) begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = S_HIGH;
                        sclk_d  = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sr_q;
                        if (hold_q) begin
                            state_d = S_IDLE;
                            held_d  = 1'b1;
                        end else begin
                            state_d  = S_GAP;
                            held_d   = 1'b0;
                            cs_act_d = 1'b0;
                            mosi_d   = 1'b0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (div_last) begin
                    if (sw_q) begin
                        state_d  = S_LEAD;
                        sw_d     = 1'b0;
                        cs_act_d = 1'b1;
                        mosi_d   = tx_q[DATA_W-1];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = ~(cs_act_d && (sel_d == SEL_W'(i)));
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule
